pattern_detector_prog: RTL and testbench
========================================

// Module: pattern_detector_prog
// PURPOSE
//  Serial bit-stream pattern detector with run-time programmable pattern/length.
//  Selectable overlapping or non-overlapping match; counts and flags matches.
//  Successor to the fixed-pattern serial detector. Sits on a 1-bit qualified data
//  stream and feeds status/interrupt logic.
// PARAMETERS
//  MAX_LEN          16        longest supported pattern, in bits (>=2)
//  CNT_W            8         match_count width, in bits
//  DEFAULT_PATTERN  16'h0035  pattern loaded at reset (7'b0110101)
//  DEFAULT_LEN      7         pattern length loaded at reset
//  DEFAULT_OVERLAP  1         overlap mode loaded at reset
// PORTS
//  clk            in   1                    clock, rising edge
//  reset          in   1                    asynchronous, active-high reset
//  stream_in      in   1                    serial data bit
//  stream_valid   in   1                    stream_in sampled only when 1
//  cfg_load       in   1                    strobe: latch cfg_* and restart hunt
//  cfg_pattern    in   MAX_LEN              pattern; bit[len-1] = first bit received
//  cfg_len        in   $clog2(MAX_LEN+1)    pattern length
//  cfg_overlap    in   1                    1 = overlapping matches allowed
//  clr_count      in   1                    strobe: clear match_count and match_seen
//  pattern_found  out  1                    1-cycle match pulse (registered)
//  match_count    out  CNT_W                saturating match counter
//  match_seen     out  1                    sticky: >=1 match since last clear
//  armed          out  1                    1 in state HUNT
// BEHAVIOUR
//  Reset: all outputs 0. hist=0, fill=0. Config regs = DEFAULT_*. State = FILL,
//   or IDLE if DEFAULT_LEN==0.
//  Effective length L = min(cfg_len, MAX_LEN). L==0 -> state IDLE, never matches.
//  History: on a valid bit, hist <= {hist[MAX_LEN-2:0], stream_in} (newest = LSB).
//  FSM, advancing only on valid bits:
//   IDLE: waits for a cfg_load with L>=1.
//   FILL: fill++ per valid bit. When fill reaches L-1 and another valid bit arrives,
//     compare and go to HUNT.
//   HUNT: compare on every valid bit.
//  Match: hist_next[L-1:0] == pattern[L-1:0], evaluated on a valid bit in HUNT,
//   or on the completing bit in FILL.
//   Timing: pattern_found goes high at the same rising edge that samples the final
//   bit, and stays high for exactly one cycle. No pulse when stream_valid=0.
//  Overlap=1: stay in HUNT. Overlap=0: after a match, fill=0, state=FILL, so the
//   next match needs L fresh bits.
//  match_count: +1 per match, saturates at 2^CNT_W-1.
//  match_seen: set on first match.
//  clr_count: clears count and flag. If a match occurs in the same cycle, the clear
//   wins, then the match is counted: count=1, seen=1.
//  cfg_load: latches cfg_pattern/len/overlap, clears hist and fill. State = FILL,
//   or IDLE if L==0. stream_in is ignored that cycle and no match is produced.
//   match_count is unaffected.
//  Async reset mid-stream: immediate return to reset values. Any partial match is
//   discarded.
// TESTING
//  1 Defaults; valid stream 0,1,1,0,1,0,1 -> pattern_found pulses on the 7th bit only;
//    match_count=1, match_seen=1.
//  2 Load 3'b101, overlap=1; stream 1,0,1,0,1 -> pulses on bits 3 and 5; count=2.
//    Repeat with overlap=0 -> pulse on bit 3 only; count=1.
//  3 Pattern 101 sent with stream_valid toggling 1,0,1,0,1 between bits
//    -> one pulse, on the last valid bit; no pulse in invalid cycles.
//  4 CNT_W=2; 5 overlapping matches of pattern 1, L=1 -> count saturates at 3.
//    clr_count coincident with a match -> count=1.
//  5 Assert reset after 5 of 7 default-pattern bits; then send the last 2 bits
//    -> no pulse; outputs 0 during reset.
//  6 cfg_load with cfg_len=0 -> armed=0, no matches on any stream.
//    cfg_len=20 (>MAX_LEN) -> L clamped to 16.

Source files
------------

// File: rtl/pattern_detector_prog.sv
// pattern_detector_prog
//   Serial bit-stream pattern detector with a run-time programmable pattern,
//   length and overlap mode. Counts matches (saturating), keeps a sticky
//   "seen" flag and emits a one-cycle registered pulse per match.
//
// Ports
//   clk_i            clock, rising edge
//   reset_i          asynchronous active-high reset
//   stream_in_i      serial data bit
//   stream_valid_i   stream_in_i is sampled only when high
//   cfg_load_i       strobe: latch cfg_* and restart the hunt
//   cfg_pattern_i    pattern; bit[L-1] is the first bit received
//   cfg_len_i        pattern length (values above MAX_LEN clamp to MAX_LEN)
//   cfg_overlap_i    1 = overlapping matches allowed
//   clr_count_i      strobe: clear match_count_o and match_seen_o
//   pattern_found_o  one-cycle match pulse
//   match_count_o    saturating match counter
//   match_seen_o     sticky: at least one match since last clear
//   armed_o          high while hunting with a full history window
//
// State | meaning
//   IDLE | effective length is 0, detector disabled until the next cfg_load
//   FILL | collecting the first L-1 fresh bits; the L-th bit is compared
//   HUNT | history window full, compare on every valid bit
module pattern_detector_prog #(
    parameter int                 MAX_LEN         = 16,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(16'h0035),
    parameter int                 DEFAULT_LEN     = 7,
    parameter bit                 DEFAULT_OVERLAP = 1'b1,
    localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               stream_in_i,
    input  logic               stream_valid_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               clr_count_i,
    output logic               pattern_found_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic               match_seen_o,
    output logic               armed_o
);

    typedef enum logic [1:0] {IDLE, FILL, HUNT} state_e;

    localparam logic [LEN_W-1:0] DEF_L = (DEFAULT_LEN > MAX_LEN) ? LEN_W'(MAX_LEN)
                                                                  : LEN_W'(DEFAULT_LEN);
    localparam state_e DEF_STATE = (DEF_L == '0) ? IDLE : FILL;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               found_q, found_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_q, seen_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   cfg_l;
    logic [CNT_W-1:0]   cnt_base;
    logic               hit;
    logic               match;

    assign cfg_l      = (cfg_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len_i;
    assign hist_shift = {hist_q[MAX_LEN-2:0], stream_in_i};

    // Only the L newest history bits take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign hit = (((hist_shift ^ pat_q) & mask) == '0);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match   = 1'b0;

        if (cfg_load_i) begin
            // A load restarts the hunt; the bit on the stream this cycle is dropped.
            pat_d   = cfg_pattern_i;
            len_d   = cfg_l;
            ovl_d   = cfg_overlap_i;
            hist_d  = '0;
            fill_d  = '0;
            state_d = (cfg_l == '0) ? IDLE : FILL;
        end else if (stream_valid_i) begin
            hist_d = hist_shift;
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FILL: begin
                    if (fill_q == len_q - LEN_W'(1)) begin
                        match  = hit;
                        fill_d = '0;
                        // Non-overlapping match keeps collecting a fresh window.
                        state_d = (hit && !ovl_q) ? FILL : HUNT;
                    end else begin
                        fill_d = fill_q + LEN_W'(1);
                    end
                end
                HUNT: begin
                    match = hit;
                    if (hit && !ovl_q) begin
                        fill_d  = '0;
                        state_d = FILL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Clear takes effect first, so a coincident match leaves count=1, seen=1.
    always_comb begin
        cnt_base = clr_count_i ? '0 : cnt_q;
        cnt_d    = (match && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
        seen_d   = (clr_count_i ? 1'b0 : seen_q) | match;
        found_d  = match;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= DEF_STATE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEFAULT_PATTERN;
            len_q   <= DEF_L;
            ovl_q   <= DEFAULT_OVERLAP;
            found_q <= 1'b0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            found_q <= found_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    assign pattern_found_o = found_q;
    assign match_count_o   = cnt_q;
    assign match_seen_o    = seen_q;
    assign armed_o         = (state_q == HUNT);

endmodule

// File: tb/tb_pattern_detector_prog.sv
module tb_pattern_detector_prog;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               stream_in = 1'b0;
    logic               stream_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               clr_count = 1'b0;
    logic               pattern_found;
    logic [CNT_W-1:0]   match_count;
    logic               match_seen;
    logic               armed;

    int total = 0;
    int bad   = 0;

    pattern_detector_prog #(
        .MAX_LEN(MAX_LEN),
        .CNT_W(CNT_W),
        .DEFAULT_PATTERN(16'h0035),
        .DEFAULT_LEN(7),
        .DEFAULT_OVERLAP(1'b1)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .stream_in_i(stream_in),
        .stream_valid_i(stream_valid),
        .cfg_load_i(cfg_load),
        .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len),
        .cfg_overlap_i(cfg_overlap),
        .clr_count_i(clr_count),
        .pattern_found_o(pattern_found),
        .match_count_o(match_count),
        .match_seen_o(match_seen),
        .armed_o(armed)
    );

    always #5 clk = ~clk;

    // Reference model: the list of received bits, how many fresh bits have
    // arrived since the last restart, and the active configuration.
    bit               m_hist[$];
    logic [15:0]      m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_fresh;
    logic [CNT_W-1:0] m_cnt;
    bit               m_seen;
    bit               m_found;
    bit               m_armed;

    task automatic model_reset();
        m_hist.delete();
        m_pat   = 16'h0035;
        m_len   = 7;
        m_ovl   = 1'b1;
        m_fresh = 0;
        m_cnt   = '0;
        m_seen  = 1'b0;
        m_found = 1'b0;
        m_armed = 1'b0;
    endtask

    // Apply one clock of stimulus, sample 1 time unit after the edge and
    // advance the reference model by the same cycle.
    task automatic cycle(input bit v, input bit b, input bit ld, input bit clr);
        bit same;
        stream_valid = v;
        stream_in    = b;
        cfg_load     = ld;
        clr_count    = clr;
        @(posedge clk);
        #1;
        stream_valid = 1'b0;
        cfg_load     = 1'b0;
        clr_count    = 1'b0;
        m_found      = 1'b0;
        if (clr) begin
            m_cnt  = '0;
            m_seen = 1'b0;
        end
        if (ld) begin
            m_pat   = cfg_pattern;
            m_len   = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl   = cfg_overlap;
            m_fresh = 0;
            m_hist.delete();
        end else if (v) begin
            m_hist.push_back(b);
            if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
            m_fresh++;
            if (m_len > 0 && m_fresh >= m_len) begin
                same = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) same = 1'b0;
                if (same) begin
                    m_found = 1'b1;
                    m_seen  = 1'b1;
                    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
                    if (!m_ovl) m_fresh = 0;
                end
            end
        end
        m_armed = (m_len > 0) && (m_fresh >= m_len);
    endtask

    task automatic load_cfg(input logic [15:0] p, input int len, input bit ovl, input bit clr);
        cfg_pattern = p;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, clr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({pattern_found, match_count, match_seen, armed} !== '0) begin
            bad++;
            $display("FAIL reset_hold: found=%b cnt=%0d seen=%b armed=%b, expected all 0",
                     pattern_found, match_count, match_seen, armed);
        end
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({pattern_found, match_count, match_seen, armed} !== '0) begin
            bad++;
            $display("FAIL reset_release: found=%b cnt=%0d seen=%b armed=%b, expected all 0",
                     pattern_found, match_count, match_seen, armed);
        end
    endtask

    task automatic test_default();
        bit seq[7] = '{0, 1, 1, 0, 1, 0, 1};
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, seq[i], 1'b0, 1'b0);
            total++;
            if ({pattern_found, match_count, match_seen, armed} !== {m_found, m_cnt, m_seen, m_armed}
                || pattern_found !== (i == 6)) begin
                bad++;
                $display("FAIL default bit%0d: found=%b cnt=%0d seen=%b armed=%b, expected %b %0d %b %b",
                         i, pattern_found, match_count, match_seen, armed, m_found, m_cnt, m_seen, m_armed);
            end
        end
        total++;
        if (match_count !== 2'd1 || match_seen !== 1'b1) begin
            bad++;
            $display("FAIL default_count: cnt=%0d seen=%b, expected 1 1", match_count, match_seen);
        end
    endtask

    task automatic test_overlap();
        bit seq[5] = '{1, 0, 1, 0, 1};
        for (int mode = 1; mode >= 0; mode--) begin
            load_cfg(16'h0005, 3, 1'(mode), 1'b1);
            for (int i = 0; i < 5; i++) begin
                cycle(1'b1, seq[i], 1'b0, 1'b0);
                total++;
                if ({pattern_found, match_count, match_seen, armed} !== {m_found, m_cnt, m_seen, m_armed}
                    || pattern_found !== ((i == 2) || (mode == 1 && i == 4))) begin
                    bad++;
                    $display("FAIL overlap%0d bit%0d: found=%b cnt=%0d seen=%b armed=%b, expected %b %0d %b %b",
                             mode, i, pattern_found, match_count, match_seen, armed,
                             m_found, m_cnt, m_seen, m_armed);
                end
            end
            total++;
            if (match_count !== ((mode == 1) ? 2'd2 : 2'd1)) begin
                bad++;
                $display("FAIL overlap%0d_count: cnt=%0d, expected %0d", mode, match_count,
                         (mode == 1) ? 2 : 1);
            end
        end
    endtask

    task automatic test_valid_gaps();
        bit vs[5] = '{1, 0, 1, 0, 1};
        bit bs[5] = '{1, 0, 0, 1, 1};
        load_cfg(16'h0005, 3, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(vs[i], vs[i] ? bs[i] : 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            total++;
            if ({pattern_found, match_count, match_seen, armed} !== {m_found, m_cnt, m_seen, m_armed}
                || pattern_found !== (i == 4)) begin
                bad++;
                $display("FAIL valid_gaps step%0d: found=%b cnt=%0d seen=%b armed=%b, expected %b %0d %b %b",
                         i, pattern_found, match_count, match_seen, armed, m_found, m_cnt, m_seen, m_armed);
            end
        end
    endtask

    task automatic test_saturate();
        logic [CNT_W-1:0] want;
        load_cfg(16'h0001, 1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            want = (i < 3) ? CNT_W'(i + 1) : 2'd3;
            total++;
            if ({pattern_found, match_count, match_seen, armed} !== {m_found, m_cnt, m_seen, m_armed}
                || match_count !== want) begin
                bad++;
                $display("FAIL saturate%0d: found=%b cnt=%0d seen=%b armed=%b, expected %b %0d %b %b",
                         i, pattern_found, match_count, match_seen, armed, m_found, want, m_seen, m_armed);
            end
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (match_count !== 2'd1 || match_seen !== 1'b1 || pattern_found !== 1'b1) begin
            bad++;
            $display("FAIL clr_with_match: found=%b cnt=%0d seen=%b, expected 1 1 1",
                     pattern_found, match_count, match_seen);
        end
    endtask

    task automatic test_reset_mid();
        bit seq[5] = '{0, 1, 1, 0, 1};
        load_cfg(16'h0035, 7, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, seq[i], 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        model_reset();
        total++;
        if ({pattern_found, match_count, match_seen, armed} !== '0) begin
            bad++;
            $display("FAIL reset_async: found=%b cnt=%0d seen=%b armed=%b, expected all 0",
                     pattern_found, match_count, match_seen, armed);
        end
        stream_valid = 1'b1;
        stream_in    = 1'b1;
        @(posedge clk);
        #1;
        stream_valid = 1'b0;
        total++;
        if ({pattern_found, match_count, match_seen, armed} !== '0) begin
            bad++;
            $display("FAIL reset_edge: found=%b cnt=%0d seen=%b armed=%b, expected all 0",
                     pattern_found, match_count, match_seen, armed);
        end
        #3 reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if ({pattern_found, match_count, match_seen, armed} !== {m_found, m_cnt, m_seen, m_armed}
            || pattern_found !== 1'b0 || armed !== 1'b0) begin
            bad++;
            $display("FAIL reset_discard: found=%b cnt=%0d seen=%b armed=%b, expected 0 0 0 0",
                     pattern_found, match_count, match_seen, armed);
        end
    endtask

    task automatic test_len_bounds();
        logic [15:0] p;
        load_cfg(16'h0000, 0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            total++;
            if (pattern_found !== 1'b0 || armed !== 1'b0 || match_count !== m_cnt) begin
                bad++;
                $display("FAIL len0 bit%0d: found=%b armed=%b cnt=%0d, expected 0 0 %0d",
                         i, pattern_found, armed, match_count, m_cnt);
            end
        end
        p = 16'($urandom);
        load_cfg(p, 20, 1'b1, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            cycle(1'b1, p[i], 1'b0, 1'b0);
            total++;
            if ({pattern_found, match_count, match_seen, armed} !== {m_found, m_cnt, m_seen, m_armed}
                || pattern_found !== (i == 0) || armed !== (i == 0)) begin
                bad++;
                $display("FAIL len_clamp bit%0d: found=%b cnt=%0d seen=%b armed=%b, expected %b %0d %b %b",
                         15 - i, pattern_found, match_count, match_seen, armed,
                         m_found, m_cnt, m_seen, m_armed);
            end
        end
    endtask

    task automatic test_random();
        int lenr;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                lenr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                                   : int'($urandom_range(1, 5));
                cfg_pattern = 16'($urandom);
                cfg_len     = LEN_W'(lenr);
                cfg_overlap = 1'($urandom_range(0, 1));
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                      ($urandom_range(0, 3) == 0));
            end else begin
                cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                      ($urandom_range(0, 29) == 0));
            end
            total++;
            if ({pattern_found, match_count, match_seen, armed} !== {m_found, m_cnt, m_seen, m_armed}) begin
                bad++;
                $display("FAIL random cyc%0d: found=%b cnt=%0d seen=%b armed=%b, expected %b %0d %b %b",
                         i, pattern_found, match_count, match_seen, armed, m_found, m_cnt, m_seen, m_armed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_overlap();
        test_valid_gaps();
        test_saturate();
        test_reset_mid();
        test_len_bounds();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
